// File: rtl/atadev_pkg.sv
// Shared definitions for the ATA PIO device emulator: task-file register indices,
// Device Control bit positions, power-on/reset signature values and FSM states.
package atadev_pkg;

    localparam logic [2:0] ATA_REG_DATA    = 3'd0;
    localparam logic [2:0] ATA_REG_ERR     = 3'd1;
    localparam logic [2:0] ATA_REG_SECCNT  = 3'd2;
    localparam logic [2:0] ATA_REG_SECNUM  = 3'd3;
    localparam logic [2:0] ATA_REG_CYLL    = 3'd4;
    localparam logic [2:0] ATA_REG_CYLH    = 3'd5;
    localparam logic [2:0] ATA_REG_DEVHEAD = 3'd6;
    localparam logic [2:0] ATA_REG_CMD     = 3'd7;
    localparam logic [2:0] ATA_REG_DEVCTRL = 3'd6;

    localparam int DEVCTRL_NIEN_BIT = 1;
    localparam int DEVCTRL_SRST_BIT = 2;

    localparam logic [7:0] SIG_SECCNT  = 8'h01;
    localparam logic [7:0] SIG_SECNUM  = 8'h01;
    localparam logic [7:0] SIG_CYLL    = 8'h00;
    localparam logic [7:0] SIG_CYLH    = 8'h00;
    localparam logic [7:0] SIG_DEVHEAD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2
    } ata_state_e;

    // Byte-wide task-file registers appear on the low half of DD.
    function automatic logic [15:0] byte_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/atadev_pio_target_if.sv
// ATA PIO host bus as seen between a host controller (master) and the device (slave).
interface atadev_pio_target_if;
    logic        ata_resetn_i;
    logic [15:0] ata_dd_i;
    logic [2:0]  ata_da_i;
    logic        ata_cs0n_i;
    logic        ata_cs1n_i;
    logic        ata_diorn_i;
    logic        ata_diown_i;
    logic [15:0] ata_dd_o;
    logic        ata_dd_oe;
    logic        ata_iordy_o;
    logic        ata_intrq_o;

    modport slave (
        input  ata_resetn_i, ata_dd_i, ata_da_i, ata_cs0n_i, ata_cs1n_i, ata_diorn_i, ata_diown_i,
        output ata_dd_o, ata_dd_oe, ata_iordy_o, ata_intrq_o
    );

    modport master (
        output ata_resetn_i, ata_dd_i, ata_da_i, ata_cs0n_i, ata_cs1n_i, ata_diorn_i, ata_diown_i,
        input  ata_dd_o, ata_dd_oe, ata_iordy_o, ata_intrq_o
    );
endinterface

// File: rtl/atadev_sync.sv
// Plain flop-chain synchroniser; every ATA input group uses the same depth so that
// strobes, select lines and data stay cycle-aligned after crossing.
module atadev_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             wb_clk_i,
    input  logic             rst_nreset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain, loaded with the idle level of the bus group on reset.
    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/atadev_pio_target.sv
// ATA-3 PIO device-side target: task-file registers, strobe FSM with IORDY stalling
// for data-port reads, interrupt logic and local-side data/command handshakes.
module atadev_pio_target
    import atadev_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TMO      = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_nreset_i,
    atadev_pio_target_if.slave    ata,
    input  logic [7:0]            status_i,
    input  logic [7:0]            error_i,
    input  logic                  irq_set_i,
    input  logic [15:0]           drd_data_i,
    input  logic                  drd_valid_i,
    output logic                  drd_ready_o,
    output logic [15:0]           dwr_data_o,
    output logic                  dwr_valid_o,
    output logic [7:0]            cmd_o,
    output logic                  cmd_valid_o,
    output logic                  srst_o,
    output logic                  rd_tmo_o
);
    localparam int              TMO_W   = (RD_TMO < 1) ? 1 : $clog2(RD_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(RD_TMO);

    logic        diorn_s, diown_s, cs0n_s, cs1n_s, ata_rstn_s;
    logic [2:0]  da_s;
    logic [15:0] dd_s, rd_mux_s;
    logic        rd_fall_s, rd_rise_s, wr_rise_s, sel_cs0_s, sel_cs1_s, devctrl_wr_s, irq_clr_s;

    ata_state_e  state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic        rd_prev_q, wr_prev_q;
    logic [7:0]  seccnt_q, seccnt_d, secnum_q, secnum_d, cyll_q, cyll_d, cylh_q, cylh_d;
    logic [7:0]  devhead_q, devhead_d, cmd_q, cmd_d;
    logic        nien_q, nien_d, srst_q, srst_d, pend_q, pend_d;
    logic [15:0] dd_q, dd_d, dwr_data_q, dwr_data_d;
    logic        oe_q, oe_d, iordy_q, iordy_d, intrq_q, intrq_d, srst_o_q, srst_o_d;
    logic        drd_ready_q, drd_ready_d, dwr_valid_q, dwr_valid_d;
    logic        cmd_valid_q, cmd_valid_d, tmo_q, tmo_d;

    atadev_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_sync_strb (
        .wb_clk_i, .rst_nreset_i, .d_i({ata.ata_diorn_i, ata.ata_diown_i}), .q_o({diorn_s, diown_s}));
    atadev_sync #(.WIDTH(5), .STAGES(SYNC_STAGES), .RST_VAL(5'b11000)) u_sync_sel (
        .wb_clk_i, .rst_nreset_i, .d_i({ata.ata_cs0n_i, ata.ata_cs1n_i, ata.ata_da_i}),
        .q_o({cs0n_s, cs1n_s, da_s}));
    atadev_sync #(.WIDTH(16), .STAGES(SYNC_STAGES), .RST_VAL(16'h0000)) u_sync_dd (
        .wb_clk_i, .rst_nreset_i, .d_i(ata.ata_dd_i), .q_o(dd_s));
    atadev_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rst (
        .wb_clk_i, .rst_nreset_i, .d_i(ata.ata_resetn_i), .q_o(ata_rstn_s));

    assign rd_fall_s    = rd_prev_q & ~diorn_s;
    assign rd_rise_s    = ~rd_prev_q & diorn_s;
    assign wr_rise_s    = ~wr_prev_q & diown_s;
    assign sel_cs0_s    = ~cs0n_s & cs1n_s;
    assign sel_cs1_s    = cs0n_s & ~cs1n_s;
    assign devctrl_wr_s = (state_q == ST_IDLE) && wr_rise_s && diorn_s && sel_cs1_s &&
                          (da_s == ATA_REG_DEVCTRL);

    // Register read multiplexer; Status/AltStatus come straight from status_i at the strobe fall.
    always_comb begin
        rd_mux_s = 16'h00FF;
        if (sel_cs0_s) begin
            case (da_s)
                ATA_REG_ERR:     rd_mux_s = byte_word(error_i);
                ATA_REG_SECCNT:  rd_mux_s = byte_word(seccnt_q);
                ATA_REG_SECNUM:  rd_mux_s = byte_word(secnum_q);
                ATA_REG_CYLL:    rd_mux_s = byte_word(cyll_q);
                ATA_REG_CYLH:    rd_mux_s = byte_word(cylh_q);
                ATA_REG_DEVHEAD: rd_mux_s = byte_word(devhead_q);
                ATA_REG_CMD:     rd_mux_s = byte_word(status_i);
                default:         rd_mux_s = 16'h0000;
            endcase
        end else if (sel_cs1_s && (da_s == ATA_REG_DEVCTRL)) begin
            rd_mux_s = byte_word(status_i);
        end else begin
            rd_mux_s = 16'h00FF;
        end
    end

    // Strobe FSM, register writes, interrupt state and both reset flavours.
    always_comb begin
        state_d = state_q;       cnt_d = cnt_q;           dd_d = dd_q;
        oe_d = oe_q;             iordy_d = iordy_q;       seccnt_d = seccnt_q;
        secnum_d = secnum_q;     cyll_d = cyll_q;         cylh_d = cylh_q;
        devhead_d = devhead_q;   nien_d = nien_q;         srst_d = srst_q;
        cmd_d = cmd_q;           dwr_data_d = dwr_data_q; pend_d = pend_q;
        drd_ready_d = 1'b0;      dwr_valid_d = 1'b0;      cmd_valid_d = 1'b0;
        tmo_d = 1'b0;            irq_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_fall_s && diown_s && (sel_cs0_s || sel_cs1_s)) begin
                    if (sel_cs0_s && (da_s == ATA_REG_DATA)) begin
                        if (drd_valid_i) begin
                            dd_d = drd_data_i; drd_ready_d = 1'b1; oe_d = 1'b1; state_d = ST_RD_DRIVE;
                        end else begin
                            iordy_d = 1'b0; cnt_d = '0; state_d = ST_RD_WAIT;
                        end
                    end else begin
                        dd_d = rd_mux_s; oe_d = 1'b1; state_d = ST_RD_DRIVE;
                        irq_clr_s = sel_cs0_s && (da_s == ATA_REG_CMD);
                    end
                end else if (wr_rise_s && diorn_s && sel_cs0_s) begin
                    case (da_s)
                        ATA_REG_DATA:    begin dwr_data_d = dd_s; dwr_valid_d = 1'b1; end
                        ATA_REG_SECCNT:  seccnt_d  = dd_s[7:0];
                        ATA_REG_SECNUM:  secnum_d  = dd_s[7:0];
                        ATA_REG_CYLL:    cyll_d    = dd_s[7:0];
                        ATA_REG_CYLH:    cylh_d    = dd_s[7:0];
                        ATA_REG_DEVHEAD: devhead_d = dd_s[7:0];
                        ATA_REG_CMD:     begin cmd_d = dd_s[7:0]; cmd_valid_d = 1'b1; irq_clr_s = 1'b1; end
                        default:         cmd_d = cmd_q;
                    endcase
                end else if (devctrl_wr_s) begin
                    nien_d = dd_s[DEVCTRL_NIEN_BIT];
                    srst_d = dd_s[DEVCTRL_SRST_BIT];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (rd_rise_s) begin
                    iordy_d = 1'b1; state_d = ST_IDLE;
                end else if (drd_valid_i) begin
                    dd_d = drd_data_i; drd_ready_d = 1'b1; iordy_d = 1'b1; oe_d = 1'b1; state_d = ST_RD_DRIVE;
                end else if (cnt_q == TMO_LIM) begin
                    dd_d = 16'hFFFF; tmo_d = 1'b1; iordy_d = 1'b1; oe_d = 1'b1; state_d = ST_RD_DRIVE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_RD_DRIVE: begin
                if (rd_rise_s) begin
                    oe_d = 1'b0; state_d = ST_IDLE;
                end else begin
                    oe_d = 1'b1;
                end
            end
            default: begin
                oe_d = 1'b0; iordy_d = 1'b1; state_d = ST_IDLE;
            end
        endcase

        // A new interrupt request outranks a clear arriving in the same cycle.
        if (irq_set_i) begin
            pend_d = 1'b1;
        end else if (irq_clr_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (!ata_rstn_s || srst_q) begin
            seccnt_d = SIG_SECCNT; secnum_d = SIG_SECNUM; cyll_d = SIG_CYLL; cylh_d = SIG_CYLH;
            devhead_d = SIG_DEVHEAD; pend_d = 1'b0; state_d = ST_IDLE; oe_d = 1'b0; iordy_d = 1'b1;
            drd_ready_d = 1'b0; dwr_valid_d = 1'b0; cmd_valid_d = 1'b0; tmo_d = 1'b0;
            // Device Control stays writable during SRST so the host can release it.
            nien_d = (ata_rstn_s && devctrl_wr_s) ? dd_s[DEVCTRL_NIEN_BIT] : 1'b0;
            srst_d = ata_rstn_s ? srst_d : 1'b0;
        end else begin
            srst_d = srst_d;
        end

        intrq_d  = pend_d & ~nien_d;
        srst_o_d = srst_d | ~ata_rstn_s;
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            state_q <= ST_IDLE;     cnt_q <= '0;            rd_prev_q <= 1'b1;   wr_prev_q <= 1'b1;
            seccnt_q <= SIG_SECCNT; secnum_q <= SIG_SECNUM; cyll_q <= SIG_CYLL;  cylh_q <= SIG_CYLH;
            devhead_q <= SIG_DEVHEAD; nien_q <= 1'b0;       srst_q <= 1'b0;      pend_q <= 1'b0;
            cmd_q <= 8'h00;         dwr_data_q <= 16'h0000; dd_q <= 16'h0000;    oe_q <= 1'b0;
            iordy_q <= 1'b1;        intrq_q <= 1'b0;        srst_o_q <= 1'b0;    drd_ready_q <= 1'b0;
            dwr_valid_q <= 1'b0;    cmd_valid_q <= 1'b0;    tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;     cnt_q <= cnt_d;         rd_prev_q <= diorn_s; wr_prev_q <= diown_s;
            seccnt_q <= seccnt_d;   secnum_q <= secnum_d;   cyll_q <= cyll_d;    cylh_q <= cylh_d;
            devhead_q <= devhead_d; nien_q <= nien_d;       srst_q <= srst_d;    pend_q <= pend_d;
            cmd_q <= cmd_d;         dwr_data_q <= dwr_data_d; dd_q <= dd_d;      oe_q <= oe_d;
            iordy_q <= iordy_d;     intrq_q <= intrq_d;     srst_o_q <= srst_o_d; drd_ready_q <= drd_ready_d;
            dwr_valid_q <= dwr_valid_d; cmd_valid_q <= cmd_valid_d; tmo_q <= tmo_d;
        end
    end

    assign ata.ata_dd_o    = dd_q;
    assign ata.ata_dd_oe   = oe_q;
    assign ata.ata_iordy_o = iordy_q;
    assign ata.ata_intrq_o = intrq_q;
    assign drd_ready_o     = drd_ready_q;
    assign dwr_data_o      = dwr_data_q;
    assign dwr_valid_o     = dwr_valid_q;
    assign cmd_o           = cmd_q;
    assign cmd_valid_o     = cmd_valid_q;
    assign srst_o          = srst_o_q;
    assign rd_tmo_o        = tmo_q;
endmodule

// File: tb/tb_atadev_pio_target.sv
// Randomised host-side bench for atadev_pio_target against a task-file level reference model.
module tb_atadev_pio_target;
    localparam int SYNC = 2;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  status_r = 8'h50, error_r = 8'h00, cmd_r;
    logic        irq_set_r = 1'b0, drd_valid_r = 1'b0;
    logic [15:0] drd_data_r = 16'h0000, dwr_data_w;
    logic        drd_ready_w, dwr_valid_w, cmd_valid_w, srst_w, rd_tmo_w;

    int n_chk = 0, n_err = 0;
    int cnt_cmd = 0, cnt_dwr = 0, cnt_pop = 0, cnt_tmo = 0;
    logic [7:0]  last_cmd = 8'h00;
    logic [15:0] last_dwr = 16'h0000;

    // Reference model of the task file, in host-visible terms.
    logic [7:0] m_reg [8];
    bit m_pend, m_nien, m_srst;

    atadev_pio_target_if ata();

    atadev_pio_target #(.SYNC_STAGES(SYNC), .RD_TMO(TMO)) dut (
        .wb_clk_i(clk), .rst_nreset_i(rst_n), .ata(ata),
        .status_i(status_r), .error_i(error_r), .irq_set_i(irq_set_r),
        .drd_data_i(drd_data_r), .drd_valid_i(drd_valid_r), .drd_ready_o(drd_ready_w),
        .dwr_data_o(dwr_data_w), .dwr_valid_o(dwr_valid_w), .cmd_o(cmd_r), .cmd_valid_o(cmd_valid_w),
        .srst_o(srst_w), .rd_tmo_o(rd_tmo_w));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid_w) begin cnt_cmd++; last_cmd = cmd_r; end
        if (dwr_valid_w) begin cnt_dwr++; last_dwr = dwr_data_w; end
        if (drd_ready_w) cnt_pop++;
        if (rd_tmo_w)    cnt_tmo++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_sig();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_reg[2] = 8'h01; m_reg[3] = 8'h01;
        m_pend = 1'b0; m_nien = 1'b0;
    endtask

    function automatic logic [15:0] m_read(input logic c0, input logic c1, input logic [2:0] a);
        if (!c0 && c1) begin
            if (a == 3'd1) return {8'h00, error_r};
            if (a == 3'd7) return {8'h00, status_r};
            return {8'h00, m_reg[a]};
        end
        if (c0 && !c1 && a == 3'd6) return {8'h00, status_r};
        return 16'h00FF;
    endfunction

    task automatic sel(input logic c0, input logic c1, input logic [2:0] a);
        ata.ata_cs0n_i = c0; ata.ata_cs1n_i = c1; ata.ata_da_i = a;
    endtask

    task automatic ata_wr(input logic c0, input logic c1, input logic [2:0] a, input logic [15:0] d);
        sel(c0, c1, a); ata.ata_dd_i = d; clks(2);
        ata.ata_diown_i = 1'b0; clks(4);
        ata.ata_diown_i = 1'b1; clks(SYNC + 3);
        sel(1'b1, 1'b1, 3'd0); clks(2);
        if (!c0 && c1 && a >= 3'd2 && a <= 3'd6 && !m_srst) m_reg[a] = d[7:0];
        if (!c0 && c1 && a == 3'd7) m_pend = 1'b0;
        if (c0 && !c1 && a == 3'd6) begin
            m_nien = d[1]; m_srst = d[2];
            if (m_srst) begin m_sig(); m_nien = d[1]; end
        end
    endtask

    task automatic rd_begin(input logic c0, input logic c1, input logic [2:0] a);
        sel(c0, c1, a); clks(2);
        ata.ata_diorn_i = 1'b0; clks(SYNC + 4);
    endtask

    task automatic rd_end(output logic oe_after);
        ata.ata_diorn_i = 1'b1; clks(SYNC + 3);
        oe_after = ata.ata_dd_oe;
        sel(1'b1, 1'b1, 3'd0); clks(2);
    endtask

    task automatic ata_rd_chk(input string tag, input logic c0, input logic c1, input logic [2:0] a);
        logic oe_aft;
        logic [15:0] exp = m_read(c0, c1, a);
        rd_begin(c0, c1, a);
        check({tag, "_dd"}, ata.ata_dd_o, exp);
        check({tag, "_oe"}, ata.ata_dd_oe, 1'b1);
        check({tag, "_iordy"}, ata.ata_iordy_o, 1'b1);
        rd_end(oe_aft);
        check({tag, "_oe_off"}, oe_aft, 1'b0);
        if (!c0 && c1 && a == 3'd7) m_pend = 1'b0;
    endtask

    task automatic irq_pulse();
        irq_set_r = 1'b1; clks(1); irq_set_r = 1'b0; clks(2);
        if (!m_srst) m_pend = 1'b1;
    endtask

    initial begin
        logic oe_aft;
        int   c0, elapsed;
        logic ok;
        ata.ata_resetn_i = 1'b1; ata.ata_dd_i = 16'h0000; ata.ata_da_i = 3'd0;
        ata.ata_cs0n_i = 1'b1; ata.ata_cs1n_i = 1'b1; ata.ata_diorn_i = 1'b1; ata.ata_diown_i = 1'b1;
        m_sig(); m_srst = 1'b0;
        clks(3);
        check("rst_oe", ata.ata_dd_oe, 1'b0);
        check("rst_iordy", ata.ata_iordy_o, 1'b1);
        check("rst_intrq", ata.ata_intrq_o, 1'b0);
        check("rst_srst", srst_w, 1'b0);
        check("rst_dd", ata.ata_dd_o, 16'h0000);
        rst_n = 1'b1; clks(SYNC + 2);

        ata_rd_chk("sig_seccnt", 1'b0, 1'b1, 3'd2);
        ata_rd_chk("sig_cylh", 1'b0, 1'b1, 3'd5);
        ata_wr(1'b0, 1'b1, 3'd3, 16'h0055);
        ata_rd_chk("secnum55", 1'b0, 1'b1, 3'd3);

        // Command, interrupt and Status/AltStatus behaviour
        c0 = cnt_cmd;
        ata_wr(1'b0, 1'b1, 3'd7, 16'h00EC);
        check("cmd_pulses", cnt_cmd - c0, 1);
        check("cmd_val", last_cmd, 8'hEC);
        irq_pulse();
        check("intrq_set", ata.ata_intrq_o, 1'b1);
        status_r = 8'h58;
        ata_rd_chk("altstat", 1'b1, 1'b0, 3'd6);
        check("intrq_alt", ata.ata_intrq_o, 1'b1);
        ata_rd_chk("status", 1'b0, 1'b1, 3'd7);
        check("intrq_clr", ata.ata_intrq_o, 1'b0);
        ata_rd_chk("cs1_other", 1'b1, 1'b0, 3'd2);

        // Data port: word already available, then a stalled read
        c0 = cnt_pop; drd_data_r = 16'h1234; drd_valid_r = 1'b1;
        rd_begin(1'b0, 1'b1, 3'd0);
        drd_valid_r = 1'b0;
        check("drd_fast_dd", ata.ata_dd_o, 16'h1234);
        rd_end(oe_aft);
        check("drd_fast_pop", cnt_pop - c0, 1);
        c0 = cnt_pop;
        rd_begin(1'b0, 1'b1, 3'd0);
        check("stall_iordy", ata.ata_iordy_o, 1'b0);
        clks(20);
        drd_data_r = 16'hA5C3; drd_valid_r = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin clks(1); ok = ata.ata_iordy_o; end
        drd_valid_r = 1'b0;
        check("stall_release", ok, 1'b1);
        clks(1);
        check("stall_dd", ata.ata_dd_o, 16'hA5C3);
        check("stall_oe", ata.ata_dd_oe, 1'b1);
        check("stall_pop", cnt_pop - c0, 1);
        rd_end(oe_aft);
        check("stall_oe_off", oe_aft, 1'b0);

        c0 = cnt_dwr;
        ata_wr(1'b0, 1'b1, 3'd0, 16'hBEEF);
        check("dwr_pulses", cnt_dwr - c0, 1);
        check("dwr_val", last_dwr, 16'hBEEF);

        // Read timeout
        c0 = cnt_tmo; elapsed = SYNC + 4;
        rd_begin(1'b0, 1'b1, 3'd0);
        for (int i = 0; i < TMO + 40 && cnt_tmo == c0; i++) begin clks(1); elapsed++; end
        check("tmo_pulse", cnt_tmo - c0, 1);
        check("tmo_window", (elapsed >= TMO) && (elapsed <= TMO + 8), 1'b1);
        check("tmo_dd", ata.ata_dd_o, 16'hFFFF);
        check("tmo_iordy", ata.ata_iordy_o, 1'b1);
        rd_end(oe_aft);

        // Soft reset through Device Control
        ata_wr(1'b0, 1'b1, 3'd2, 16'h0033);
        irq_pulse();
        check("pre_srst_intrq", ata.ata_intrq_o, 1'b1);
        ata_wr(1'b1, 1'b0, 3'd6, 16'h0004);
        check("srst_on", srst_w, 1'b1);
        check("srst_intrq", ata.ata_intrq_o, 1'b0);
        ata_wr(1'b1, 1'b0, 3'd6, 16'h0002);
        check("srst_off", srst_w, 1'b0);
        ata_rd_chk("srst_seccnt", 1'b0, 1'b1, 3'd2);
        irq_pulse();
        check("nien_mask", ata.ata_intrq_o, 1'b0);
        ata_wr(1'b1, 1'b0, 3'd6, 16'h0000);
        check("nien_unmask", ata.ata_intrq_o, m_pend & ~m_nien);

        // Illegal select: both chip selects active
        rd_begin(1'b0, 1'b0, 3'd3);
        check("illegal_oe", ata.ata_dd_oe, 1'b0);
        rd_end(oe_aft);

        // Hardware reset while stalled in a data read
        ata_wr(1'b0, 1'b1, 3'd4, 16'h0077);
        rd_begin(1'b0, 1'b1, 3'd0);
        check("hrst_pre_iordy", ata.ata_iordy_o, 1'b0);
        ata.ata_resetn_i = 1'b0; clks(SYNC + 3);
        check("hrst_iordy", ata.ata_iordy_o, 1'b1);
        check("hrst_srst", srst_w, 1'b1);
        ata.ata_resetn_i = 1'b1; clks(SYNC + 3);
        check("hrst_srst_rel", srst_w, 1'b0);
        rd_end(oe_aft);
        check("hrst_oe", oe_aft, 1'b0);
        m_sig(); m_srst = 1'b0;
        ata_rd_chk("hrst_cyll", 1'b0, 1'b1, 3'd4);

        // Randomised register traffic against the model
        for (int it = 0; it < 40; it++) begin
            int op = $urandom_range(0, 4);
            logic [2:0] a = 3'($urandom_range(2, 6));
            case (op)
                0: ata_wr(1'b0, 1'b1, a, 16'($urandom));
                1: begin
                    error_r = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) a = 3'd1;
                    ata_rd_chk("rnd_reg", 1'b0, 1'b1, a);
                end
                2: irq_pulse();
                3: begin status_r = 8'($urandom); ata_rd_chk("rnd_stat", 1'b0, 1'b1, 3'd7); end
                default: begin status_r = 8'($urandom); ata_rd_chk("rnd_alt", 1'b1, 1'b0, 3'd6); end
            endcase
            check("rnd_intrq", ata.ata_intrq_o, m_pend & ~m_nien);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
